// File: rtl/dist2freq_step_interp_if.sv
// Lookup request / table-write / result bundle for the distance-to-frequency-step interpolator.
interface dist2freq_step_interp_if #(
  parameter int ADDR_W   = 13,
  parameter int STEP_W   = 32,
  parameter int SEG_BITS = 5
);
  logic                enable;
  logic                in_valid;
  logic [ADDR_W-1:0]   address;
  logic                tbl_wr_en;
  logic [SEG_BITS:0]   tbl_wr_addr;
  logic [STEP_W-1:0]   tbl_wr_data;
  logic                out_valid;
  logic [STEP_W-1:0]   freq_step;
  logic                out_of_range;

  modport master (
    output enable, in_valid, address, tbl_wr_en, tbl_wr_addr, tbl_wr_data,
    input  out_valid, freq_step, out_of_range
  );
  modport slave (
    input  enable, in_valid, address, tbl_wr_en, tbl_wr_addr, tbl_wr_data,
    output out_valid, freq_step, out_of_range
  );
endinterface

// File: rtl/dist2freq_step_interp.sv
// Distance code -> DDS frequency step via linear interpolation over a loadable
// breakpoint table; 3-stage pipeline with out-of-range mute and global enable.
module dist2freq_step_interp #(
  parameter int ADDR_W   = 13,
  parameter int STEP_W   = 32,
  parameter int SEG_BITS = 5,
  parameter int MAX_DIST = 8191
) (
  input  logic clk,
  input  logic reset_n,
  dist2freq_step_interp_if.slave bus
);
  localparam int FRAC_W = ADDR_W - SEG_BITS;
  localparam int DEPTH  = 2**SEG_BITS + 1;
  localparam int P_W    = STEP_W + FRAC_W + 2;
  localparam int STAGES = 3;
  localparam logic [SEG_BITS:0] TOP_IDX = {1'b1, {SEG_BITS{1'b0}}};
  localparam logic [ADDR_W:0]   MAX_D   = (ADDR_W+1)'(MAX_DIST);

  typedef struct packed {
    logic [STEP_W-1:0] lo;
    logic [STEP_W-1:0] hi;
    logic [FRAC_W-1:0] frac;
    logic              en;
    logic              oor;
  } s1_t;

  typedef struct packed {
    logic [STEP_W-1:0] lo;
    logic [STEP_W-1:0] sh;
    logic              en;
    logic              oor;
  } s2_t;

  logic [STEP_W-1:0]   tbl [DEPTH];
  logic [STAGES-1:0]   vld_pipe;
  s1_t                 s1, s1_c;
  s2_t                 s2, s2_c;
  logic [SEG_BITS:0]   seg_lo, seg_hi;
  logic signed [STEP_W:0] d;
  logic signed [P_W-1:0]  p;
  logic [STEP_W-1:0]   result, freq_q;
  logic                oor_q;

  assign seg_lo = {1'b0, bus.address[ADDR_W-1:FRAC_W]};
  assign seg_hi = seg_lo + (SEG_BITS+1)'(1);

  // Writes land at the edge, so a same-cycle lookup still sees the old entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else if (bus.tbl_wr_en && bus.tbl_wr_addr <= TOP_IDX) begin
      tbl[bus.tbl_wr_addr] <= bus.tbl_wr_data;
    end
  end

  always_comb begin
    s1_c      = '0;
    s1_c.lo   = tbl[seg_lo];
    s1_c.hi   = tbl[seg_hi];
    s1_c.frac = bus.address[FRAC_W-1:0];
    s1_c.en   = bus.enable;
    s1_c.oor  = {1'b0, bus.address} >= MAX_D;
  end

  // Only the low STEP_W bits of the shifted product matter: the final sum is
  // bounded by lo..hi, so modular addition yields the exact result.
  always_comb begin
    d       = $signed({1'b0, s1.hi}) - $signed({1'b0, s1.lo});
    p       = P_W'(d) * P_W'($signed({1'b0, s1.frac}));
    s2_c    = '0;
    s2_c.lo = s1.lo;
    s2_c.sh = STEP_W'(p >>> FRAC_W);
    s2_c.en = s1.en;
    s2_c.oor = s1.oor;
  end

  assign result = s2.lo + s2.sh;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
      freq_q   <= '0;
      oor_q    <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-2:0], bus.in_valid};
      if (bus.in_valid) s1 <= s1_c;
      if (vld_pipe[0])  s2 <= s2_c;
      if (vld_pipe[1]) begin
        freq_q <= (s2.en && !s2.oor) ? result : '0;
        oor_q  <= s2.oor;
      end
    end
  end

  assign bus.out_valid    = vld_pipe[STAGES-1];
  assign bus.freq_step    = freq_q;
  assign bus.out_of_range = oor_q;
endmodule

// File: tb/tb_dist2freq_step_interp.sv
// Scoreboard bench: default build plus a MAX_DIST=4000 build driven in lockstep.
module tb_dist2freq_step_interp;
  localparam int ADDR_W = 13, STEP_W = 32, SEG_BITS = 5, FRAC_W = 8;

  typedef struct {
    int          due;
    logic [31:0] f0, f1;
    logic        o0, o1;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0, checks = 0, cyc = 0;
  bit   started = 0;
  exp_t sbq [$];
  logic [31:0] mt [33];
  logic [31:0] last_f0 = '0, last_f1 = '0;
  logic        last_o0 = 1'b0, last_o1 = 1'b0;

  dist2freq_step_interp_if #(.ADDR_W(ADDR_W), .STEP_W(STEP_W), .SEG_BITS(SEG_BITS)) b ();
  dist2freq_step_interp_if #(.ADDR_W(ADDR_W), .STEP_W(STEP_W), .SEG_BITS(SEG_BITS)) bm ();

  assign bm.enable      = b.enable;
  assign bm.in_valid    = b.in_valid;
  assign bm.address     = b.address;
  assign bm.tbl_wr_en   = b.tbl_wr_en;
  assign bm.tbl_wr_addr = b.tbl_wr_addr;
  assign bm.tbl_wr_data = b.tbl_wr_data;

  dist2freq_step_interp #(.ADDR_W(ADDR_W), .STEP_W(STEP_W), .SEG_BITS(SEG_BITS), .MAX_DIST(8191))
    dut (.clk(clk), .reset_n(reset_n), .bus(b));
  dist2freq_step_interp #(.ADDR_W(ADDR_W), .STEP_W(STEP_W), .SEG_BITS(SEG_BITS), .MAX_DIST(4000))
    dut_m (.clk(clk), .reset_n(reset_n), .bus(bm));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] interp(input logic [12:0] a);
    int     seg;
    longint lo, hi, p;
    seg = int'(a[12:8]);
    lo  = longint'(mt[seg]);
    hi  = longint'(mt[seg+1]);
    p   = (hi - lo) * longint'(a[7:0]);
    return 32'(lo + (p >>> FRAC_W));
  endfunction

  // Lookup against the pre-write table, then apply the write, mirroring the edge.
  always @(posedge clk) begin
    cyc++;
    if (reset_n && started) begin
      if (b.in_valid) begin
        exp_t e;
        logic [31:0] r;
        r    = interp(b.address);
        e.due = cyc + 2;
        e.o0 = (b.address >= 13'd8191);
        e.o1 = (b.address >= 13'd4000);
        e.f0 = (b.enable && !e.o0) ? r : 32'd0;
        e.f1 = (b.enable && !e.o1) ? r : 32'd0;
        sbq.push_back(e);
      end
      if (b.tbl_wr_en && b.tbl_wr_addr <= 6'd32) mt[int'(b.tbl_wr_addr)] = b.tbl_wr_data;
    end
  end

  always @(negedge clk) begin
    if (reset_n && started) begin
      logic exp_v;
      while (sbq.size() > 0 && sbq[0].due < cyc) void'(sbq.pop_front());
      exp_v = (sbq.size() > 0) && (sbq[0].due == cyc);
      chk("out_valid", 64'(b.out_valid), 64'(exp_v));
      chk("out_valid_m", 64'(bm.out_valid), 64'(exp_v));
      if (exp_v) begin
        exp_t e;
        e = sbq.pop_front();
        chk("freq_step", 64'(b.freq_step), 64'(e.f0));
        chk("out_of_range", 64'(b.out_of_range), 64'(e.o0));
        chk("freq_step_m", 64'(bm.freq_step), 64'(e.f1));
        chk("out_of_range_m", 64'(bm.out_of_range), 64'(e.o1));
        last_f0 = e.f0; last_o0 = e.o0; last_f1 = e.f1; last_o1 = e.o1;
      end else begin
        chk("hold_freq", 64'(b.freq_step), 64'(last_f0));
        chk("hold_oor", 64'(b.out_of_range), 64'(last_o0));
        chk("hold_freq_m", 64'(bm.freq_step), 64'(last_f1));
      end
    end
  end

  task automatic step(input logic v, input logic en, input int a,
                      input logic we, input int wa, input int wd);
    @(negedge clk);
    b.in_valid    = v;
    b.enable      = en;
    b.address     = 13'(a);
    b.tbl_wr_en   = we;
    b.tbl_wr_addr = 6'(wa);
    b.tbl_wr_data = 32'(wd);
  endtask

  task automatic clear_model();
    sbq.delete();
    for (int k = 0; k < 33; k++) mt[k] = '0;
    last_f0 = '0; last_f1 = '0; last_o0 = 1'b0; last_o1 = 1'b0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_out_valid", 64'(b.out_valid), 64'd0);
    chk("rst_freq_step", 64'(b.freq_step), 64'd0);
    chk("rst_out_of_range", 64'(b.out_of_range), 64'd0);
    chk("rst_out_valid_m", 64'(bm.out_valid), 64'd0);
  endtask

  task automatic load_linear();
    for (int k = 0; k <= 32; k++) step(0, 1, 0, 1, k, k * 256);
  endtask

  initial begin
    b.in_valid = 0; b.enable = 0; b.address = '0;
    b.tbl_wr_en = 0; b.tbl_wr_addr = '0; b.tbl_wr_data = '0;
    clear_model();
    repeat (3) @(negedge clk);
    #1 check_reset_outputs();
    @(negedge clk);
    reset_n = 1; started = 1;

    // Linear table: every code maps to itself, streamed back to back.
    load_linear();
    for (int a = 0; a < 8192; a++) step(1, 1, a, 0, 0, 0);

    // Rising and falling segments, breakpoint and floor rounding.
    step(0, 1, 0, 1, 3, 1000);
    step(0, 1, 0, 1, 4, 2000);
    step(1, 1, 896, 0, 0, 0);
    step(1, 1, 768, 0, 0, 0);
    step(0, 1, 0, 1, 3, 2000);
    step(0, 1, 0, 1, 4, 1000);
    step(1, 1, 832, 0, 0, 0);
    step(1, 1, 769, 0, 0, 0);

    // Out-of-range boundary and enable mute.
    load_linear();
    step(1, 1, 3999, 0, 0, 0);
    step(1, 1, 4000, 0, 0, 0);
    step(1, 0, 100, 0, 0, 0);
    step(1, 1, 8190, 0, 0, 0);
    step(1, 1, 8191, 0, 0, 0);
    step(1, 0, 5000, 0, 0, 0);

    // Same-edge write/read, then an out-of-table write index.
    step(1, 1, 1280, 1, 5, 9999);
    step(1, 1, 1280, 0, 0, 0);
    step(0, 1, 0, 1, 33, 32'h0BAD_F00D);
    for (int k = 0; k < 32; k++) step(1, 1, k * 256 + 128, 0, 0, 0);
    step(1, 1, 8191 - 1, 0, 0, 0);

    // Bubbles between valid samples.
    for (int i = 0; i < 10; i++) step((i % 2) == 0, 1, 300 * i + 7, 0, 0, 0);

    // Reset with work in flight; inputs valid straight after release.
    step(1, 1, 100, 0, 0, 0);
    step(1, 1, 200, 0, 0, 0);
    step(1, 1, 300, 0, 0, 0);
    @(posedge clk);
    #2 reset_n = 0;
    clear_model();
    #1 check_reset_outputs();
    repeat (2) @(negedge clk);
    reset_n = 1;
    b.in_valid = 1; b.enable = 1; b.address = 13'd1234; b.tbl_wr_en = 0;
    for (int i = 0; i < 6; i++) step(1, 1, 1000 * i + 55, 0, 0, 0);

    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 0);
    chk("drain", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
